// File: rtl/fetch_stage.sv
// fetch_stage: PC-driven imem read feeding decode through a valid/ready slot.
// Optional saturating perf counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter int PC_W = 8,
  parameter int INSTR_W = 16,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_cur,
  output logic [PC_W-1:0]    pc_next,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_bubbles
`endif
);

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  localparam int DEPTH = 1 << PC_W;

  state_t state;

  logic [INSTR_W-1:0] mem [0:DEPTH-1];

  logic accept;
  logic advance;
  logic halt_hit;
  logic do_fetch;

  assign accept   = id_valid & id_ready;
  assign advance  = (state == RUN) & (!id_valid | id_ready);
  assign halt_hit = (state == RUN) & accept &
                    (id_instr == HALT_INSTR);
  assign do_fetch = !redirect_valid & !halt_hit & advance;

  always_comb begin
    pc_next = pc_cur;
    if (redirect_valid)
      pc_next = redirect_target;
    else if (halt_hit)
      pc_next = pc_cur;
    else if (advance)
      pc_next = pc_cur + 1'b1;
  end

  // Program-load port; contents survive reset.
  always_ff @(posedge clk) begin
    if (imem_we)
      mem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      halted   <= 1'b0;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else begin
      unique case (1'b1)
        redirect_valid: begin
          state    <= RUN;
          halted   <= 1'b0;
          id_valid <= 1'b0;
        end
        (!redirect_valid & halt_hit): begin
          state    <= HALTED;
          halted   <= 1'b1;
          id_valid <= 1'b0;
        end
        do_fetch: begin
          id_instr <= mem[pc_cur];
          id_pc    <= pc_cur;
          id_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic bubble;

  assign bubble = (state == RUN) & id_ready & !id_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (accept && perf_fetched != 16'hFFFF)
        perf_fetched <= perf_fetched + 1'b1;
      if (bubble && perf_bubbles != 16'hFFFF)
        perf_bubbles <= perf_bubbles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus accept scoreboard for fetch_stage.
// A local PC register closes the pc_next -> pc_cur loop.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [7:0]  pc_q;
  logic [7:0]  pc_next;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_bubbles;
`endif

  int checks;
  int fails;

  typedef struct {
    logic        ready;
    logic        rv;
    logic [7:0]  tgt;
    logic        ev;
    logic [15:0] ei;
    logic [7:0]  ep;
    logic [7:0]  ec;
    logic [7:0]  en;
    logic        eh;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
  } exp_t;

  exp_t sb[$];

  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .pc_cur(pc_q),
    .pc_next(pc_next),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .imem_we(imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .halted(halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pc_q <= '0;
    else
      pc_q <= pc_next;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Every handshake must match the oldest expected delivery.
  always @(negedge clk) begin
    if (rst && id_valid && id_ready) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_extra actual=%h/%h required=none",
                 id_instr, id_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (id_instr !== e.instr || id_pc !== e.pc) begin
          fails++;
          $display("FAIL sb_accept actual=%h/%h required=%h/%h",
                   id_instr, id_pc, e.instr, e.pc);
        end
      end
    end
  end

  task automatic apply(input vec_t v, input string nm);
    id_ready        = v.ready;
    redirect_valid  = v.rv;
    redirect_target = v.tgt;
    if (v.ev && v.ready) begin
      exp_t e;
      e.instr = v.ei;
      e.pc    = v.ep;
      sb.push_back(e);
    end
    @(negedge clk);
    chk({nm, "_valid"}, 32'(id_valid), 32'(v.ev));
    if (v.ev) begin
      chk({nm, "_instr"}, 32'(id_instr), 32'(v.ei));
      chk({nm, "_pc"}, 32'(id_pc), 32'(v.ep));
    end
    chk({nm, "_pccur"}, 32'(pc_q), 32'(v.ec));
    chk({nm, "_pcnext"}, 32'(pc_next), 32'(v.en));
    chk({nm, "_halted"}, 32'(halted), 32'(v.eh));
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
  endtask

  vec_t t1[12];
  vec_t t2[6];
  vec_t v;

  initial begin
    checks = 0;
    fails  = 0;
    rst = 1'b0;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;
    imem_we = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;

    t1[0]  = '{1, 0, 8'h00, 0, 16'h0000, 8'h00, 8'h00, 8'h01, 0};
    t1[1]  = '{1, 0, 8'h00, 1, 16'h1000, 8'h00, 8'h01, 8'h02, 0};
    t1[2]  = '{0, 0, 8'h00, 1, 16'h1001, 8'h01, 8'h02, 8'h02, 0};
    t1[3]  = '{0, 0, 8'h00, 1, 16'h1001, 8'h01, 8'h02, 8'h02, 0};
    t1[4]  = '{0, 0, 8'h00, 1, 16'h1001, 8'h01, 8'h02, 8'h02, 0};
    t1[5]  = '{1, 0, 8'h00, 1, 16'h1001, 8'h01, 8'h02, 8'h03, 0};
    t1[6]  = '{1, 1, 8'h40, 1, 16'h1002, 8'h02, 8'h03, 8'h40, 0};
    t1[7]  = '{1, 0, 8'h00, 0, 16'h0000, 8'h00, 8'h40, 8'h41, 0};
    t1[8]  = '{0, 1, 8'h10, 1, 16'hABCD, 8'h40, 8'h41, 8'h10, 0};
    t1[9]  = '{1, 0, 8'h00, 0, 16'h0000, 8'h00, 8'h10, 8'h11, 0};
    t1[10] = '{1, 0, 8'h00, 1, 16'h5010, 8'h10, 8'h11, 8'h12, 0};
    t1[11] = '{1, 0, 8'h00, 1, 16'h5011, 8'h11, 8'h12, 8'h13, 0};

    t2[0] = '{0, 1, 8'hFF, 0, 16'h0000, 8'h00, 8'h00, 8'hFF, 0};
    t2[1] = '{1, 0, 8'h00, 0, 16'h0000, 8'h00, 8'hFF, 8'h00, 0};
    t2[2] = '{1, 0, 8'h00, 1, 16'hEEFF, 8'hFF, 8'h00, 8'h01, 0};
    t2[3] = '{1, 0, 8'h00, 1, 16'h1000, 8'h00, 8'h01, 8'h02, 0};
    t2[4] = '{1, 0, 8'h00, 1, 16'h1001, 8'h01, 8'h02, 8'h03, 0};
    t2[5] = '{1, 0, 8'h00, 1, 16'hFFFF, 8'h02, 8'h03, 8'h03, 0};

    #2;
    for (int i = 0; i < 5; i++)
      wr(8'(i), 16'h1000 + 16'(i));
    wr(8'h40, 16'hABCD);
    wr(8'h10, 16'h5010);
    wr(8'h11, 16'h5011);
    wr(8'h12, 16'h1234);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", 32'(id_instr), 32'd0);
    chk("rst_pc", 32'(id_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_pf", 32'(perf_fetched), 32'd0);
    chk("rst_pb", 32'(perf_bubbles), 32'd0);
`endif
    rst = 1'b1;

    for (int i = 0; i < 12; i++)
      apply(t1[i], $sformatf("p1_%0d", i));

    // Asynchronous reset between edges with a live slot.
    #2;
    chk("pre_rst_valid", 32'(id_valid), 32'd1);
    chk("pre_rst_instr", 32'(id_instr), 32'h1234);
    rst = 1'b0;
    #1;
    chk("async_valid", 32'(id_valid), 32'd0);
    chk("async_instr", 32'(id_instr), 32'd0);
    chk("async_pc", 32'(id_pc), 32'd0);
    chk("async_pcq", 32'(pc_q), 32'd0);
`ifdef FETCH_PERF_EN
    chk("async_pf", 32'(perf_fetched), 32'd0);
    chk("async_pb", 32'(perf_bubbles), 32'd0);
`endif
    @(posedge clk);
    #1;
    wr(8'h02, 16'hFFFF);
    wr(8'hFF, 16'hEEFF);
    rst = 1'b1;

    for (int i = 0; i < 6; i++)
      apply(t2[i], $sformatf("p2_%0d", i));

    for (int i = 0; i < 10; i++) begin
      id_ready = 1'(i & 1);
      @(negedge clk);
      chk($sformatf("halt_valid_%0d", i), 32'(id_valid), 32'd0);
      chk($sformatf("halt_flag_%0d", i), 32'(halted), 32'd1);
      chk($sformatf("halt_pc_%0d", i), 32'(pc_q), 32'h03);
      chk($sformatf("halt_next_%0d", i), 32'(pc_next), 32'h03);
      @(posedge clk);
      #1;
    end

    v = '{1, 1, 8'h00, 0, 16'h0000, 8'h00, 8'h03, 8'h00, 1};
    apply(v, "resume_rd");
    v = '{1, 0, 8'h00, 0, 16'h0000, 8'h00, 8'h00, 8'h01, 0};
    apply(v, "resume_bub");
    v = '{1, 0, 8'h00, 1, 16'h1000, 8'h00, 8'h01, 8'h02, 0};
    apply(v, "resume_fetch");

    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Consumes the current PC, reads a local synchronous instruction memory, and presents instruction plus PC to decode over a valid/ready handshake.
- Computes the next-PC value that feeds back into the PC register: sequential, held, or redirected.
- Handles decode back-pressure, branch/jump redirects (flush) and a HALT instruction.

Parameters:
- PC_W, 8, PC width; also the imem address width.
- INSTR_W, 16, instruction width.
- HALT_INSTR, 16'hFFFF, encoding that stops fetch once accepted by decode.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pc_cur  in  PC_W  current PC from the PC register output.
- pc_next  out  PC_W  next PC to the PC register input; combinational.
- redirect_valid  in  1  one-cycle pulse; branch/jump taken.
- redirect_target  in  PC_W  target PC, sampled when redirect_valid=1.
- id_valid  out  1  instruction slot to decode holds valid data.
- id_ready  in  1  decode accepts the slot this cycle.
- id_instr  out  INSTR_W  fetched instruction.
- id_pc  out  PC_W  address of id_instr.
- imem_we  in  1  program-load write enable.
- imem_waddr  in  PC_W  write address.
- imem_wdata  in  INSTR_W  write data.
- halted  out  1  fetch is stopped in HALTED.

Behaviour:
- Reset (rst=0, async): id_valid=0, id_instr=0, id_pc=0, halted=0, state=RUN. Imem contents are not reset.
- States:
  - RUN: fetching.
  - HALTED: no fetch; halted=1.
- accept = id_valid & id_ready.
- advance = state==RUN & (!id_valid | id_ready).
- pc_next priority:
  - redirect_valid → redirect_target.
  - RUN & accept & id_instr==HALT_INSTR → pc_cur.
  - advance → pc_cur+1, modulo 2^PC_W; 255 wraps to 0 at default width.
  - otherwise → pc_cur (hold).
- Registered update, priority order:
  - redirect_valid: id_valid<=0 (flushes the slot and discards this cycle's fetch); state<=RUN; halted<=0; id_instr/id_pc don't-care.
  - RUN & accept & id_instr==HALT_INSTR: state<=HALTED, halted<=1, id_valid<=0; no fetch is issued this cycle.
  - advance: id_instr<=imem[pc_cur], id_pc<=pc_cur, id_valid<=1.
  - otherwise (stall): id_valid/id_instr/id_pc hold unchanged.
- Latency and throughput:
  - An instruction at PC A appears on id_instr one edge after pc_cur==A with advance=1.
  - With decode always ready: one instruction per cycle after one initial cycle; first id_valid=1 at the first edge after reset release.
  - Redirect cost: one bubble cycle. The target instruction is valid two edges after the redirect pulse.
- Redirect vs stall, same cycle: redirect wins; the slot is flushed even though id_ready=0.
- Redirect in HALTED: leaves HALTED. pc_next=target, and fetch resumes the following cycle.
- HALTED: id_valid stays 0, pc_next=pc_cur; the PC stays at halt address+1. id_ready is ignored.
- Imem:
  - Synchronous write on imem_we.
  - Read-during-write to the same address returns old data.
  - Writes allowed in any state.
- Reset mid-operation: all outputs go to reset values immediately. Any slot contents are lost.

Optional Feature:
- Macro FETCH_PERF_EN. When defined, adds two outputs:
  - perf_fetched [15:0]: increments on each accept.
  - perf_bubbles [15:0]: increments each cycle with state==RUN, id_ready=1, id_valid=0.
  - Both reset to 0 on rst and saturate at 16'hFFFF.
- Not defined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Straight-line fetch:
  - Load imem[0..3]=16'h1000..16'h1003; id_ready=1; release reset with the PC register attached.
  - Required: id_valid rises after the first edge; id_instr=1000,1001,1002,1003 on consecutive cycles with id_pc=0..3.
- Stall:
  - Hold id_ready=0 for 3 cycles while id_instr=16'h1001, id_pc=1.
  - Required: outputs held, pc_next=pc_cur=2. After release, 16'h1002 follows with no duplicate or skipped instruction.
- Redirect:
  - Pulse redirect_valid with target 8'h40 while id_pc=2; imem[0x40]=16'hABCD.
  - Required: next cycle id_valid=0. One cycle later id_instr=16'hABCD, id_pc=8'h40.
- Redirect during stall:
  - id_ready=0 and redirect to 8'h10 in the same cycle.
  - Required: slot flushed (id_valid=0); then imem[0x10] delivered.
- Wrap and HALT:
  - Fetch from 8'hFF; then pc_next=0.
  - Place HALT_INSTR at 0x02 and accept it.
  - Required: halted=1, id_valid stays 0, pc_cur stays 3 for 10 cycles. A redirect to 0x00 resumes fetch.
- Async reset mid-stream:
  - Assert rst=0 between edges while id_valid=1.
  - Required: id_valid, id_pc, id_instr go to 0 immediately. With FETCH_PERF_EN, counters read 0.
